hazard_forward_unit: RTL and testbench

//  Pipeline-hazard controller: the decode-side producer of the ID/EX control fields and the EX-side reader of them.

---
 rtl/hazard_forward_unit.sv | 115 +++++++++++
 tb/tb_hazard_forward_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard controller: shadow scoreboard of the instructions in EX, MEM and WB.
// It produces the load-use stall and the ID/EX bubble, the EX-stage operand forwarding
// selects, the ID-stage write-through bypass, and a saturating count of stall cycles.
module hazard_forward_unit #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             IDvalid,
  input  logic [RA_W-1:0]  IDrs1,
  input  logic [RA_W-1:0]  IDrs2,
  input  logic             IDuseRs1,
  input  logic             IDuseRs2,
  input  logic [RA_W-1:0]  IDrd,
  input  logic             IDregWrite,
  input  logic             IDmemRead,
  input  logic             Redirect,
  output logic             Stall,
  output logic             IDEXBubble,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             BypassA,
  output logic             BypassB,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Valid bits are the only scoreboard state that needs a reset; the other
  // fields are don't-care whenever their stage is invalid.
  logic            ex_vld_q, mem_vld_q, wb_vld_q;
  logic            ex_vld_d;
  logic [RA_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q, mem_rd_q, wb_rd_q;
  logic            ex_rw_q, ex_mr_q, mem_rw_q, wb_rw_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_wr, mem_wr, wb_wr, lu;

  // Forward select for one EX operand; the younger MEM result beats WB.
  function automatic logic [1:0] fwd_sel(
    input logic            ex_vld,
    input logic [RA_W-1:0] rs,
    input logic            mem_wr_f,
    input logic [RA_W-1:0] mem_rd_f,
    input logic            wb_wr_f,
    input logic [RA_W-1:0] wb_rd_f
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_vld) begin
      if (mem_wr_f && (mem_rd_f == rs))     sel = 2'b10;
      else if (wb_wr_f && (wb_rd_f == rs))  sel = 2'b01;
    end
    return sel;
  endfunction

  // Hazard detection, forwarding/bypass selects and the next EX valid bit.
  always_comb begin
    ex_wr  = ex_vld_q  & ex_rw_q  & (ex_rd_q  != '0);
    mem_wr = mem_vld_q & mem_rw_q & (mem_rd_q != '0);
    wb_wr  = wb_vld_q  & wb_rw_q  & (wb_rd_q  != '0);

    lu = IDvalid & ex_wr & ex_mr_q &
         ((IDuseRs1 & (IDrs1 == ex_rd_q)) | (IDuseRs2 & (IDrs2 == ex_rd_q)));

    // A redirect kills the ID instruction instead of holding it.
    Stall      = lu & ~Redirect;
    IDEXBubble = RSTn & (lu | Redirect);
    ex_vld_d   = IDvalid & ~IDEXBubble;

    ForwardA = fwd_sel(ex_vld_q, ex_rs1_q, mem_wr, mem_rd_q, wb_wr, wb_rd_q);
    ForwardB = fwd_sel(ex_vld_q, ex_rs2_q, mem_wr, mem_rd_q, wb_wr, wb_rd_q);

    BypassA = IDvalid & IDuseRs1 & wb_wr & (wb_rd_q == IDrs1);
    BypassB = IDvalid & IDuseRs2 & wb_wr & (wb_rd_q == IDrs2);

    cnt_d = (Stall && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Scoreboard valid bits advance EX->MEM->WB every edge; reset empties it.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ex_vld_q  <= 1'b0;
      mem_vld_q <= 1'b0;
      wb_vld_q  <= 1'b0;
    end else begin
      ex_vld_q  <= ex_vld_d;
      mem_vld_q <= ex_vld_q;
      wb_vld_q  <= mem_vld_q;
    end
  end

  // Scoreboard payload fields; gated by the valid bits above.
  always_ff @(posedge CLK) begin
    ex_rs1_q <= IDrs1;
    ex_rs2_q <= IDrs2;
    ex_rd_q  <= IDrd;
    ex_rw_q  <= IDregWrite;
    ex_mr_q  <= IDmemRead;
    mem_rd_q <= ex_rd_q;
    mem_rw_q <= ex_rw_q;
    wb_rd_q  <= mem_rd_q;
    wb_rw_q  <= mem_rw_q;
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign StallCount = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed hazard scenarios with literal
// expectations plus randomized traffic checked every cycle against a queue model.
module tb_hazard_forward_unit;
  localparam int RA_W  = 5;
  localparam int CNT_W = 10;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK, RSTn, IDvalid, IDuseRs1, IDuseRs2, IDregWrite, IDmemRead, Redirect;
  logic [RA_W-1:0]  IDrs1, IDrs2, IDrd;
  logic             Stall, IDEXBubble, BypassA, BypassB;
  logic [1:0]       ForwardA, ForwardB;
  logic [CNT_W-1:0] StallCount;

  hazard_forward_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .IDvalid(IDvalid), .IDrs1(IDrs1), .IDrs2(IDrs2),
    .IDuseRs1(IDuseRs1), .IDuseRs2(IDuseRs2), .IDrd(IDrd), .IDregWrite(IDregWrite),
    .IDmemRead(IDmemRead), .Redirect(Redirect), .Stall(Stall), .IDEXBubble(IDEXBubble),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .BypassA(BypassA), .BypassB(BypassB),
    .StallCount(StallCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v; int rs1; int rs2; int rd; bit rw; bit mr;
  } ent_t;

  ent_t pipe[$];   // [0]=EX, [1]=MEM, [2]=WB
  int   mcount;

  function automatic void m_clear();
    ent_t e;
    e = '{v: 0, rs1: 0, rs2: 0, rd: 0, rw: 0, mr: 0};
    pipe.delete();
    repeat (3) pipe.push_back(e);
  endfunction

  function automatic bit writer(input ent_t e);
    return e.v && e.rw && (e.rd != 0);
  endfunction

  function automatic bit m_lu();
    ent_t ex;
    ex = pipe[0];
    return IDvalid && writer(ex) && ex.mr &&
           ((IDuseRs1 && int'(IDrs1) == ex.rd) || (IDuseRs2 && int'(IDrs2) == ex.rd));
  endfunction

  function automatic int m_fwd(input int rs);
    if (!pipe[0].v) return 0;
    if (writer(pipe[1]) && pipe[1].rd == rs) return 2;
    if (writer(pipe[2]) && pipe[2].rd == rs) return 1;
    return 0;
  endfunction

  function automatic bit m_byp(input bit use_rs, input int rs);
    return IDvalid && use_rs && writer(pipe[2]) && pipe[2].rd == rs;
  endfunction

  initial begin
    ent_t n;
    bit lu, bub;
    m_clear();
    mcount = 0;
    forever begin
      @(posedge CLK);
      if (!RSTn) begin
        m_clear();
        mcount = 0;
      end else begin
        lu  = m_lu();
        bub = lu || Redirect;
        if (lu && !Redirect && mcount < CMAX) mcount++;
        n = '{v: IDvalid && !bub, rs1: int'(IDrs1), rs2: int'(IDrs2), rd: int'(IDrd),
              rw: IDregWrite, mr: IDmemRead};
        pipe.push_front(n);
        void'(pipe.pop_back());
      end
      @(negedge CLK);
      if (!RSTn) begin
        m_clear();
        mcount = 0;
      end
      lu = m_lu();
      chk("m_stall",  32'(Stall),      32'(lu && !Redirect));
      chk("m_bubble", 32'(IDEXBubble), 32'(RSTn && (lu || Redirect)));
      chk("m_fwdA",   32'(ForwardA),   32'(m_fwd(pipe[0].rs1)));
      chk("m_fwdB",   32'(ForwardB),   32'(m_fwd(pipe[0].rs2)));
      chk("m_bypA",   32'(BypassA),    32'(m_byp(IDuseRs1, int'(IDrs1))));
      chk("m_bypB",   32'(BypassB),    32'(m_byp(IDuseRs2, int'(IDrs2))));
      chk("m_count",  32'(StallCount), 32'(mcount));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit redir);
    IDvalid = v; IDrs1 = RA_W'(r1); IDuseRs1 = u1; IDrs2 = RA_W'(r2); IDuseRs2 = u2;
    IDrd = RA_W'(rd); IDregWrite = rw; IDmemRead = mr; Redirect = redir;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_drive();
    drive($urandom % 8 != 0, int'($urandom % 8), 1'($urandom), int'($urandom % 8),
          1'($urandom), int'($urandom % 8), 1'($urandom), $urandom % 3 == 0,
          $urandom % 16 == 0);
  endtask

  task automatic edge_drive();
    @(posedge CLK); #1;
  endtask

  task automatic flush();
    repeat (3) begin edge_drive(); nop(); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RSTn = 1'b0;
    nop();
    // Reset with random inputs
    repeat (3) begin
      edge_drive(); rand_drive();
      @(negedge CLK);
      chk("rst_stall", 32'(Stall), 0);
      chk("rst_fwd",   32'({ForwardA, ForwardB}), 0);
      chk("rst_byp",   32'({BypassA, BypassB}), 0);
      chk("rst_cnt",   32'(StallCount), 0);
    end
    edge_drive(); RSTn = 1'b1; nop();
    flush();

    // lw x5 ; add x6,x5,x7
    edge_drive(); drive(1, 2, 1, 0, 0, 5, 1, 1, 0);
    edge_drive(); drive(1, 5, 1, 7, 1, 6, 1, 0, 0);
    @(negedge CLK);
    chk("lu_stall",  32'(Stall), 1);
    chk("lu_bubble", 32'(IDEXBubble), 1);
    edge_drive();                               // ID held
    @(negedge CLK);
    chk("lu_stall_once", 32'(Stall), 0);
    chk("lu_count",      32'(StallCount), 1);
    edge_drive(); nop();
    @(negedge CLK);
    chk("lu_fwdA_wb", 32'(ForwardA), 1);
    chk("lu_fwdB",    32'(ForwardB), 0);
    flush();

    // add x3 ; sub x4,x3,x3
    edge_drive(); drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
    edge_drive(); drive(1, 3, 1, 3, 1, 4, 1, 0, 0);
    edge_drive(); nop();
    @(negedge CLK);
    chk("ex_fwdA_mem", 32'(ForwardA), 2);
    chk("ex_fwdB_mem", 32'(ForwardB), 2);
    flush();

    // add x3 ; add x3 ; or x8,x3,x0
    edge_drive(); drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
    edge_drive(); drive(1, 4, 1, 5, 1, 3, 1, 0, 0);
    edge_drive(); drive(1, 3, 1, 0, 1, 8, 1, 0, 0);
    edge_drive(); nop();
    @(negedge CLK);
    chk("young_fwdA", 32'(ForwardA), 2);
    chk("x0_fwdB",    32'(ForwardB), 0);
    flush();

    // add x0 ; use x0
    edge_drive(); drive(1, 1, 1, 2, 1, 0, 1, 0, 0);
    edge_drive(); drive(1, 0, 1, 0, 1, 10, 1, 0, 0);
    @(negedge CLK);
    chk("x0_nostall", 32'(Stall), 0);
    edge_drive(); nop();
    @(negedge CLK);
    chk("x0_nofwd", 32'({ForwardA, ForwardB}), 0);
    flush();
    // lw x0 ; use x0
    edge_drive(); drive(1, 1, 1, 0, 0, 0, 1, 1, 0);
    edge_drive(); drive(1, 0, 1, 0, 1, 11, 1, 0, 0);
    @(negedge CLK);
    chk("lw_x0_stall", 32'(Stall), 0);
    flush();

    // lw x5 ; lw x6,(x5) with Redirect in the same cycle
    edge_drive(); drive(1, 2, 1, 0, 0, 5, 1, 1, 0);
    edge_drive(); drive(1, 5, 1, 0, 0, 6, 1, 1, 1);
    @(negedge CLK);
    chk("redir_stall",  32'(Stall), 0);
    chk("redir_bubble", 32'(IDEXBubble), 1);
    edge_drive(); drive(1, 6, 1, 0, 0, 7, 1, 0, 0);
    @(negedge CLK);
    chk("redir_killed", 32'(Stall), 0);
    flush();

    // add x9 ; nop ; nop ; use x9 (WB write-through)
    edge_drive(); drive(1, 1, 1, 2, 1, 9, 1, 0, 0);
    edge_drive(); nop();
    edge_drive(); nop();
    edge_drive(); drive(1, 9, 1, 9, 1, 12, 1, 0, 0);
    @(negedge CLK);
    chk("bypA", 32'(BypassA), 1);
    chk("bypB", 32'(BypassB), 1);
    flush();

    // Reset asserted in the middle of a stall
    edge_drive(); drive(1, 2, 1, 0, 0, 4, 1, 1, 0);
    edge_drive(); drive(1, 4, 1, 0, 0, 13, 1, 0, 0);
    @(negedge CLK);
    chk("mid_stall", 32'(Stall), 1);
    #2 RSTn = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(Stall), 0);
    chk("mid_rst_cnt",   32'(StallCount), 0);
    edge_drive(); RSTn = 1'b1; nop();
    @(negedge CLK);
    chk("post_rst_fwd", 32'({ForwardA, ForwardB}), 0);

    // Randomized traffic with occasional resets
    repeat (3000) begin
      edge_drive();
      RSTn = ($urandom % 300) != 0;
      rand_drive();
    end
    edge_drive(); RSTn = 1'b1; nop();
    flush();

    // Drive the counter into saturation
    repeat (CMAX + 2) begin
      edge_drive(); drive(1, 2, 1, 0, 0, 1, 1, 1, 0);
      edge_drive(); drive(1, 1, 1, 0, 0, 14, 1, 0, 0);
      edge_drive();
    end
    edge_drive(); nop();
    @(negedge CLK);
    chk("cnt_sat", 32'(StallCount), 32'(CMAX));
    edge_drive(); drive(1, 2, 1, 0, 0, 1, 1, 1, 0);
    edge_drive(); drive(1, 1, 1, 0, 0, 14, 1, 0, 0);
    @(negedge CLK);
    chk("sat_stall", 32'(Stall), 1);
    edge_drive(); nop();
    @(negedge CLK);
    chk("cnt_hold", 32'(StallCount), 32'(CMAX));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
